avalon_dual_master_arbiter: RTL and testbench

- Two-to-one Avalon-MM arbiter downstream of the RISC-V Avalon wrapper.
- Merges the instruction master port (m0) and the external/data master port (m1) onto a single Avalon-MM master port that drives the shared memory/peripheral slave.
- Round-robin grant with LOCK support and per-transfer BEGINTRANSFER generation.
- Optional hang watchdog on the downstream slave.

---
 rtl/avalon_dual_master_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_avalon_dual_master_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_dual_master_arbiter
//
// Merges two Avalon-MM masters (m0 = instruction port, m1 = external/data
// port) onto one downstream Avalon-MM master port. Grants are round-robin.
// LOCK keeps the grant across back-to-back transfers. BEGINTRANSFER is
// regenerated downstream once per transfer.
//
// Handshake: a master holds ADDRESS/WRITEDATA/READ/WRITE stable while its
// WAITREQUEST is 1. A transfer completes in the cycle where the granted
// master requests (READ|WRITE) and s_WAITREQUEST is 0. Read data is valid to
// the granted master in that completion cycle only. READ and WRITE asserted
// together are treated as a write.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When it is defined, a watchdog counts consecutive stalled cycles of the
//   granted transfer. When the count reaches TIMEOUT_CYCLES, the next cycle
//   is a forced completion: READDATA = 32'hDEADBEEF, the downstream strobes
//   drop, arb_error is set (sticky until reset) and the FSM returns to IDLE.
//   When it is undefined, there is no watchdog and arb_error is tied to 0.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   m0_* / m1_*                upstream Avalon-MM slave-side ports
//   s_*                        downstream Avalon-MM master-side port
//   arb_error                  sticky watchdog timeout flag
//   dbg_state                  current FSM state (0 IDLE, 1 GNT0, 2 GNT1)
// ---------------------------------------------------------------------------
module avalon_dual_master_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    // master 0 (instruction)
    input  logic [WIDTH-1:0] m0_ADDRESS,
    input  logic             m0_BEGINTRANSFER,
    input  logic             m0_READ,
    input  logic             m0_WRITE,
    input  logic [WIDTH-1:0] m0_WRITEDATA,
    input  logic             m0_LOCK,
    output logic [WIDTH-1:0] m0_READDATA,
    output logic             m0_WAITREQUEST,
    // master 1 (external / data)
    input  logic [WIDTH-1:0] m1_ADDRESS,
    input  logic             m1_BEGINTRANSFER,
    input  logic             m1_READ,
    input  logic             m1_WRITE,
    input  logic [WIDTH-1:0] m1_WRITEDATA,
    input  logic             m1_LOCK,
    output logic [WIDTH-1:0] m1_READDATA,
    output logic             m1_WAITREQUEST,
    // downstream slave
    output logic [WIDTH-1:0] s_ADDRESS,
    output logic [WIDTH-1:0] s_WRITEDATA,
    output logic             s_BEGINTRANSFER,
    output logic             s_READ,
    output logic             s_WRITE,
    output logic             s_LOCK,
    input  logic [WIDTH-1:0] s_READDATA,
    input  logic             s_WAITREQUEST,
    // status / debug
    output logic             arb_error,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEAD_WORD = WIDTH'(32'hDEADBEEF);

    state_t state, state_next;
    logic   last_grant;     // 0: m0 was last served, 1: m1 was last served
    logic   in_transfer;    // a transfer was started and has not completed
    logic   in_transfer_next;

    logic req0, req1;
    logic gnt_any, sel1;
    logic g_req, g_read, g_write, g_lock;
    logic [WIDTH-1:0] g_addr, g_wdata;
    logic done;
    logic forced;           // watchdog-forced completion this cycle

    assign req0 = m0_READ | m0_WRITE;
    assign req1 = m1_READ | m1_WRITE;

    assign gnt_any = (state == GNT0) || (state == GNT1);
    assign sel1    = (state == GNT1);

    // Granted master's request signals. A simultaneous READ+WRITE is a write.
    assign g_req   = sel1 ? req1 : req0;
    assign g_write = sel1 ? m1_WRITE : m0_WRITE;
    assign g_read  = (sel1 ? m1_READ : m0_READ) & ~g_write;
    assign g_lock  = sel1 ? m1_LOCK : m0_LOCK;
    assign g_addr  = sel1 ? m1_ADDRESS : m0_ADDRESS;
    assign g_wdata = sel1 ? m1_WRITEDATA : m0_WRITEDATA;

    assign done = gnt_any & g_req & (~s_WAITREQUEST | forced);

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            in_transfer <= 1'b0;
        end else begin
            state       <= state_next;
            in_transfer <= in_transfer_next;
            if (done) begin
                last_grant <= sel1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (req0) begin
                    state_next = GNT0;
                end else if (req1) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (forced) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = g_lock ? state : IDLE;
                end else if (!g_req && !g_lock) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A transfer stays "started" from its first granted request cycle until it
    // completes; this suppresses BEGINTRANSFER during wait states.
    assign in_transfer_next = gnt_any & g_req & ~done & (state_next == state);

    // -----------------------------------------------------------------------
    // Output routing
    // -----------------------------------------------------------------------
    always_comb begin
        s_ADDRESS       = '0;
        s_WRITEDATA     = '0;
        s_READ          = 1'b0;
        s_WRITE         = 1'b0;
        s_LOCK          = 1'b0;
        s_BEGINTRANSFER = 1'b0;
        m0_READDATA     = '0;
        m1_READDATA     = '0;
        m0_WAITREQUEST  = req0;
        m1_WAITREQUEST  = req1;

        if (gnt_any) begin
            s_ADDRESS       = g_addr;
            s_WRITEDATA     = g_wdata;
            s_LOCK          = g_lock;
            s_READ          = g_read & ~forced;
            s_WRITE         = g_write & ~forced;
            s_BEGINTRANSFER = g_req & ~in_transfer & ~forced;
            m0_READDATA     = s_READDATA;
            m1_READDATA     = s_READDATA;
            if (sel1) begin
                m0_WAITREQUEST = 1'b1;
                m1_WAITREQUEST = req1 & s_WAITREQUEST & ~forced;
                if (forced) begin
                    m1_READDATA = DEAD_WORD;
                end
            end else begin
                m1_WAITREQUEST = 1'b1;
                m0_WAITREQUEST = req0 & s_WAITREQUEST & ~forced;
                if (forced) begin
                    m0_READDATA = DEAD_WORD;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // Hang watchdog
    // -----------------------------------------------------------------------
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          arb_error_q;

    assign forced    = gnt_any & g_req & (wd_cnt == CW'(TIMEOUT_CYCLES));
    assign arb_error = arb_error_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt      <= '0;
            arb_error_q <= 1'b0;
        end else begin
            // Count only consecutive stalled cycles of the same grant.
            if (gnt_any && g_req && s_WAITREQUEST && !forced && (state_next == state)) begin
                wd_cnt <= wd_cnt + CW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (forced) begin
                arb_error_q <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign forced         = 1'b0;
    assign arb_error      = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Upstream BEGINTRANSFER is regenerated downstream, so the inputs are unused.
    logic unused_begintransfer;
    assign unused_begintransfer = m0_BEGINTRANSFER ^ m1_BEGINTRANSFER;

endmodule

// File: tb/tb_avalon_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_dual_master_arbiter
//
// Testbench for avalon_dual_master_arbiter. Each table row holds the inputs
// for one clock cycle and the outputs expected in that cycle. Inputs change
// on the falling edge and outputs are sampled 1 ns before the rising edge.
// Hand-written sequences cover async reset mid-transfer and the watchdog.
// ---------------------------------------------------------------------------
module tb_avalon_dual_master_arbiter;

  localparam int W = 32;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dut signals
  logic [W-1:0] m0_address, m0_writedata, m0_readdata;
  logic         m0_begintransfer, m0_read, m0_write, m0_lock, m0_waitrequest;
  logic [W-1:0] m1_address, m1_writedata, m1_readdata;
  logic         m1_begintransfer, m1_read, m1_write, m1_lock, m1_waitrequest;
  logic [W-1:0] s_address, s_writedata, s_readdata;
  logic         s_begintransfer, s_read, s_write, s_lock, s_waitrequest;
  logic         arb_error;
  logic [1:0]   dbg_state;

  avalon_dual_master_arbiter #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .m0_ADDRESS       (m0_address),
    .m0_BEGINTRANSFER (m0_begintransfer),
    .m0_READ          (m0_read),
    .m0_WRITE         (m0_write),
    .m0_WRITEDATA     (m0_writedata),
    .m0_LOCK          (m0_lock),
    .m0_READDATA      (m0_readdata),
    .m0_WAITREQUEST   (m0_waitrequest),
    .m1_ADDRESS       (m1_address),
    .m1_BEGINTRANSFER (m1_begintransfer),
    .m1_READ          (m1_read),
    .m1_WRITE         (m1_write),
    .m1_WRITEDATA     (m1_writedata),
    .m1_LOCK          (m1_lock),
    .m1_READDATA      (m1_readdata),
    .m1_WAITREQUEST   (m1_waitrequest),
    .s_ADDRESS        (s_address),
    .s_WRITEDATA      (s_writedata),
    .s_BEGINTRANSFER  (s_begintransfer),
    .s_READ           (s_read),
    .s_WRITE          (s_write),
    .s_LOCK           (s_lock),
    .s_READDATA       (s_readdata),
    .s_WAITREQUEST    (s_waitrequest),
    .arb_error        (arb_error),
    .dbg_state        (dbg_state)
  );

  // vector record: inputs for one cycle, then expected outputs in that cycle
  typedef struct {
    logic       r0, w0, l0;
    logic [W-1:0] a0, d0;
    logic       r1, w1, l1;
    logic [W-1:0] a1, d1;
    logic       swait;
    logic [W-1:0] srd;
    logic [1:0] st;
    logic       sr, sw, sbt, sl;
    logic [W-1:0] saddr, swd;
    logic       wq0, wq1;
    logic [W-1:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_writedata = '0;
    m0_begintransfer = 0; m1_begintransfer = 0;
    s_waitrequest = 0; s_readdata = '0;
  endtask

  task automatic drive_vec(input vec_t x);
    m0_read = x.r0; m0_write = x.w0; m0_lock = x.l0; m0_address = x.a0; m0_writedata = x.d0;
    m1_read = x.r1; m1_write = x.w1; m1_lock = x.l1; m1_address = x.a1; m1_writedata = x.d1;
    s_waitrequest = x.swait; s_readdata = x.srd;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    chk($sformatf("v%0d_state", i), W'(dbg_state), W'(x.st));
    chk($sformatf("v%0d_s_read", i), W'(s_read), W'(x.sr));
    chk($sformatf("v%0d_s_write", i), W'(s_write), W'(x.sw));
    chk($sformatf("v%0d_s_begin", i), W'(s_begintransfer), W'(x.sbt));
    chk($sformatf("v%0d_s_lock", i), W'(s_lock), W'(x.sl));
    chk($sformatf("v%0d_s_addr", i), s_address, x.saddr);
    chk($sformatf("v%0d_s_wdata", i), s_writedata, x.swd);
    chk($sformatf("v%0d_m0_wait", i), W'(m0_waitrequest), W'(x.wq0));
    chk($sformatf("v%0d_m1_wait", i), W'(m1_waitrequest), W'(x.wq1));
    chk($sformatf("v%0d_m0_rdata", i), m0_readdata, x.rd0);
    chk($sformatf("v%0d_m1_rdata", i), m1_readdata, x.rd1);
  endtask

  // global bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  gcyc;
    bit  hit;

    // ---------------- vector table ----------------
    // contention after reset: m0 wins, then m1, then m0 again
    v = '{T,F,F,32'h200,32'h0, T,F,F,32'h300,32'h0, F,32'h11, 2'd0,F,F,F,F,32'h0,32'h0,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h200,32'h0, T,F,F,32'h300,32'h0, F,32'h11, 2'd1,T,F,T,F,32'h200,32'h0,F,T,32'h11,32'h11}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, T,F,F,32'h300,32'h0, F,32'h11, 2'd0,F,F,F,F,32'h0,32'h0,F,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, T,F,F,32'h300,32'h0, F,32'h11, 2'd2,T,F,T,F,32'h300,32'h0,T,F,32'h11,32'h11}; vecs.push_back(v);
    v = '{F,T,F,32'h204,32'hAAAA, T,F,F,32'h304,32'h0, F,32'h22, 2'd0,F,F,F,F,32'h0,32'h0,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,T,F,32'h204,32'hAAAA, T,F,F,32'h304,32'h0, F,32'h22, 2'd1,F,T,T,F,32'h204,32'hAAAA,F,T,32'h22,32'h22}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, T,F,F,32'h304,32'h0, F,32'h22, 2'd0,F,F,F,F,32'h0,32'h0,F,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, T,F,F,32'h304,32'h0, F,32'h22, 2'd2,T,F,T,F,32'h304,32'h0,T,F,32'h22,32'h22}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,F,F,32'h0,32'h0, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,F,32'h0,32'h0}; vecs.push_back(v);
    // single zero-wait read by m0
    v = '{T,F,F,32'h100,32'h0, F,F,F,32'h0,32'h0, F,32'h12345678, 2'd0,F,F,F,F,32'h0,32'h0,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h100,32'h0, F,F,F,32'h0,32'h0, F,32'h12345678, 2'd1,T,F,T,F,32'h100,32'h0,F,T,32'h12345678,32'h12345678}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,F,F,32'h0,32'h0, F,32'h12345678, 2'd0,F,F,F,F,32'h0,32'h0,F,F,32'h0,32'h0}; vecs.push_back(v);
    // READ and WRITE together on m1 is a write
    v = '{F,F,F,32'h0,32'h0, T,T,F,32'h400,32'h55, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, T,T,F,32'h400,32'h55, F,32'h0, 2'd2,F,T,T,F,32'h400,32'h55,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,F,F,32'h0,32'h0, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,F,32'h0,32'h0}; vecs.push_back(v);
    // locked m1 writes while m0 requests continuously
    v = '{F,F,F,32'h0,32'h0, F,T,T,32'hA0,32'h1, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,T,T,32'hA0,32'h1, F,32'h0, 2'd2,F,T,T,T,32'hA0,32'h1,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,T,T,32'hA4,32'h2, F,32'h0, 2'd2,F,T,T,T,32'hA4,32'h2,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,T,T,32'hA8,32'h3, F,32'h0, 2'd2,F,T,T,T,32'hA8,32'h3,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,F,F,32'h0,32'h0, F,32'h0, 2'd2,F,F,F,F,32'h0,32'h0,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,F,F,32'h0,32'h0, F,32'h33, 2'd0,F,F,F,F,32'h0,32'h0,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{T,F,F,32'h500,32'h0, F,F,F,32'h0,32'h0, F,32'h33, 2'd1,T,F,T,F,32'h500,32'h0,F,T,32'h33,32'h33}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,F,F,32'h0,32'h0, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,F,32'h0,32'h0}; vecs.push_back(v);
    // m1 write with 4 slave wait states
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, T,32'h0, 2'd2,F,T,T,F,32'h600,32'hCAFE,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, T,32'h0, 2'd2,F,T,F,F,32'h600,32'hCAFE,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, T,32'h0, 2'd2,F,T,F,F,32'h600,32'hCAFE,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, T,32'h0, 2'd2,F,T,F,F,32'h600,32'hCAFE,T,T,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,T,F,32'h600,32'hCAFE, F,32'h0, 2'd2,F,T,F,F,32'h600,32'hCAFE,T,F,32'h0,32'h0}; vecs.push_back(v);
    v = '{F,F,F,32'h0,32'h0, F,F,F,32'h0,32'h0, F,32'h0, 2'd0,F,F,F,F,32'h0,32'h0,F,F,32'h0,32'h0}; vecs.push_back(v);

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive_idle();
    m0_read = 1; m0_address = 32'h100; s_readdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_state", W'(dbg_state), W'(2'd0));
    chk("rst_m0_wait", W'(m0_waitrequest), W'(1'b1));
    chk("rst_m1_wait", W'(m1_waitrequest), W'(1'b0));
    chk("rst_s_read", W'(s_read), W'(1'b0));
    chk("rst_s_addr", s_address, 32'h0);
    chk("rst_m0_rdata", m0_readdata, 32'h0);
    chk("rst_arb_error", W'(arb_error), W'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #4;
      check_vec(i, vecs[i]);
    end
    chk("table_arb_error", W'(arb_error), W'(1'b0));

    // ---------------- async reset mid-transfer ----------------
    @(negedge clk);
    drive_idle();
    m0_read = 1; m0_address = 32'h700; s_waitrequest = 1;
    #4;
    chk("rstmid_idle", W'(dbg_state), W'(2'd0));
    @(negedge clk);
    #1;
    chk("rstmid_granted", W'(dbg_state), W'(2'd1));
    chk("rstmid_s_read_before", W'(s_read), W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rstmid_s_read_dropped", W'(s_read), W'(1'b0));
    chk("rstmid_state_idle", W'(dbg_state), W'(2'd0));
    chk("rstmid_m0_wait", W'(m0_waitrequest), W'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    s_waitrequest = 0; s_readdata = 32'h77;
    #4;
    chk("rstmid_post_idle", W'(dbg_state), W'(2'd0));
    chk("rstmid_post_wait", W'(m0_waitrequest), W'(1'b1));
    @(negedge clk);
    #4;
    chk("rstmid_regrant_state", W'(dbg_state), W'(2'd1));
    chk("rstmid_regrant_read", W'(s_read), W'(1'b1));
    chk("rstmid_regrant_begin", W'(s_begintransfer), W'(1'b1));
    chk("rstmid_regrant_rdata", m0_readdata, 32'h77);
    @(negedge clk);
    drive_idle();

    // ---------------- hung slave ----------------
    @(negedge clk);
    m0_read = 1; m0_address = 32'h800; s_waitrequest = 1;
`ifdef ARB_TIMEOUT_EN
    gcyc = 0;
    hit  = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      if (dbg_state == 2'd1) begin
        gcyc++;
        if (!m0_waitrequest) hit = 1;
      end
    end
    chk("wd_forced_seen", W'(hit), W'(1'b1));
    chk("wd_gnt_cycles", W'(gcyc), W'(9));
    chk("wd_rdata", m0_readdata, 32'hDEADBEEF);
    chk("wd_s_read_low", W'(s_read), W'(1'b0));
    @(negedge clk);
    #1;
    chk("wd_state_idle", W'(dbg_state), W'(2'd0));
    chk("wd_arb_error", W'(arb_error), W'(1'b1));
    drive_idle();
    // a normal transfer afterwards leaves the flag set
    @(negedge clk);
    m1_write = 1; m1_address = 32'h900; m1_writedata = 32'h9;
    @(negedge clk);
    #4;
    chk("wd_after_write", W'(s_write), W'(1'b1));
    @(negedge clk);
    drive_idle();
    #4;
    chk("wd_arb_error_sticky", W'(arb_error), W'(1'b1));
`else
    gcyc = 0;
    hit  = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      if (dbg_state == 2'd1) gcyc++;
      if (dbg_state == 2'd1 && !m0_waitrequest) hit = 1;
    end
    chk("hang_stall_cycles", W'(gcyc), W'(19));
    chk("hang_never_released", W'(hit), W'(1'b0));
    chk("hang_arb_error", W'(arb_error), W'(1'b0));
    chk("hang_s_read_held", W'(s_read), W'(1'b1));
    @(negedge clk);
    s_waitrequest = 0; s_readdata = 32'h88;
    #4;
    chk("hang_release_rdata", m0_readdata, 32'h88);
    chk("hang_release_wait", W'(m0_waitrequest), W'(1'b0));
    @(negedge clk);
    drive_idle();
`endif

    // ---------------- report ----------------
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
